snake_head_stepper: RTL and testbench

//  Game-tick head-position generator for the snake datapath, directly upstream of the 5-bit

---
 rtl/snake_head_stepper.sv | 127 ++++++++++++
 tb/tb_snake_head_stepper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
// Head-position stepper for the snake datapath: latches the requested direction, rejects reversals
// and advances the head one cell per step tick, applying wrap or wall rules at the grid edges.
module snake_head_stepper #(
  parameter int unsigned COORD_W   = 5,
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter int unsigned START_X   = 16,
  parameter int unsigned START_Y   = 12,
  parameter logic [1:0]  START_DIR = 2'b00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               step_tick,
  input  logic               pause,
  input  logic               wrap_en,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [1:0]         dir,
  output logic               head_valid,
  output logic               wall_hit
);

  localparam logic [1:0] DirRight = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirUp    = 2'b11;

  localparam logic [COORD_W-1:0] XMax     = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMax     = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] PlusOne  = COORD_W'(1);
  localparam logic [COORD_W-1:0] MinusOne = '1;

  typedef enum logic [1:0] {StRun, StPaused, StDead} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [1:0]         dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic               head_valid_q, head_valid_d, wall_hit_q, wall_hit_d;

  logic               btn_any, step, at_edge, wall;
  logic [1:0]         req;
  logic [COORD_W-1:0] dx, dy, wrap_x, wrap_y, next_x, next_y;

  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        req = DirUp;
    else if (btn_down) req = DirDown;
    else if (btn_left) req = DirLeft;
    else               req = DirRight;

    // Reversal is judged against the committed direction, not the pending one.
    pend_dir_d = pend_dir_q;
    if (state_q != StDead && btn_any && ((req ^ dir_q) != 2'b10)) begin
      pend_dir_d = req;
    end

    step    = step_tick && !pause && (state_q == StRun);
    dx      = '0;
    dy      = '0;
    at_edge = 1'b0;
    wrap_x  = head_x_q;
    wrap_y  = head_y_q;
    unique case (pend_dir_q)
      DirRight: begin dx = PlusOne;  at_edge = (head_x_q == XMax); wrap_x = '0;   end
      DirLeft:  begin dx = MinusOne; at_edge = (head_x_q == '0);   wrap_x = XMax; end
      DirDown:  begin dy = PlusOne;  at_edge = (head_y_q == YMax); wrap_y = '0;   end
      DirUp:    begin dy = MinusOne; at_edge = (head_y_q == '0);   wrap_y = YMax; end
      default:  ;
    endcase
    next_x = at_edge ? wrap_x : head_x_q + dx;
    next_y = at_edge ? wrap_y : head_y_q + dy;
    wall   = step && at_edge && !wrap_en;

    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    dir_d        = dir_q;
    head_valid_d = step && !wall;
    wall_hit_d   = wall_hit_q | wall;
    if (step && !wall) begin
      head_x_d = next_x;
      head_y_d = next_y;
      dir_d    = pend_dir_q;
    end

    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (pause)     state_d = StPaused;
        else if (wall) state_d = StDead;
      end
      StPaused: if (!pause) state_d = StRun;
      StDead:   state_d = StDead;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      head_x_q     <= COORD_W'(START_X);
      head_y_q     <= COORD_W'(START_Y);
      dir_q        <= START_DIR;
      pend_dir_q   <= START_DIR;
      head_valid_q <= 1'b0;
      wall_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      head_valid_q <= head_valid_d;
      wall_hit_q   <= wall_hit_d;
    end
  end

  assign head_x     = head_x_q;
  assign head_y     = head_y_q;
  assign dir        = dir_q;
  assign head_valid = head_valid_q;
  assign wall_hit   = wall_hit_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper: expected head positions are queued as ticks are
// driven and popped when the head_valid pulse appears.
module tb_snake_head_stepper;

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_down, btn_left, btn_right, step_tick, pause, wrap_en;
  logic [4:0] head_x, head_y;
  logic [1:0] dir;
  logic       head_valid, wall_hit;

  typedef struct packed {
    logic       valid;
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] d;
  } obs_t;

  obs_t sb[$];
  obs_t got, e;
  int   n_cmp = 0;
  int   n_err = 0;

  snake_head_stepper dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .step_tick  (step_tick),
    .pause      (pause),
    .wrap_en    (wrap_en),
    .head_x     (head_x),
    .head_y     (head_y),
    .dir        (dir),
    .head_valid (head_valid),
    .wall_hit   (wall_hit)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic v, input int x, input int y, input logic [1:0] d);
    obs_t o;
    o.valid = v;
    o.x     = 5'(x);
    o.y     = 5'(y);
    o.d     = d;
    return o;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    got = {head_valid, head_x, head_y, dir};
  endtask

  task automatic press(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
    cycle();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Drives one tick cycle; a stepping tick queues its expected head first.
  task automatic tick(input bit stepping, input int x, input int y, input logic [1:0] d);
    if (stepping) sb.push_back(mk(1'b1, x, y, d));
    step_tick = 1'b1;
    cycle();
    step_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_cmp++;
    if (got !== mk(1'b0, 16, 12, 2'b00)) begin
      n_err++;
      $display("FAIL reset_head: got v=%b x=%0d y=%0d dir=%0d, required v=0 x=16 y=12 dir=0",
               got.valid, got.x, got.y, got.d);
    end
    n_cmp++;
    if (wall_hit !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wall: got %b, required 0", wall_hit);
    end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 17 + i, 12, 2'b00);
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL straight_step%0d: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
                 i, got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
      end
      cycle();
      n_cmp++;
      if (head_valid !== 1'b0) begin
        n_err++;
        $display("FAIL straight_pulse%0d: head_valid got %b, required 0", i, head_valid);
      end
      cycle();
      cycle();
    end
  endtask

  task automatic test_reversal();
    press(4'b0010);
    tick(1'b1, 20, 12, 2'b00);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reversal_step%0d: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
                 i, got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
      end
      if (i == 0) begin
        press(4'b1000);
        tick(1'b1, 20, 11, 2'b11);
      end
    end
  endtask

  // Holds step_tick high to step every cycle while checking each pop.
  task automatic run_b2b(input string name, input int n, input int x0, input int y0,
                         input int sx, input int sy, input logic [1:0] d, input int ywrap_at);
    int x, y;
    x = x0;
    y = y0;
    step_tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      x = x + sx;
      y = (i == ywrap_at) ? 23 : y + sy;
      sb.push_back(mk(1'b1, x, y, d));
      cycle();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s_%0d: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
                 name, i, got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
      end
    end
    step_tick = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    wrap_en = 1'b1;
    run_b2b("b2b_right", 15, 16, 12, 1, 0, 2'b00, -1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(1'b1, 0, 12, 2'b00);
      if (i == 1) begin press(4'b1000); tick(1'b1, 0, 11, 2'b11); end
      if (i == 2) begin press(4'b0010); tick(1'b1, 31, 11, 2'b10); end
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL wrap_%0d: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
                 i, got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
      end
    end
    press(4'b1000);
    run_b2b("wrap_up", 12, 31, 11, 0, -1, 2'b11, 11);
  endtask

  task automatic test_wall();
    do_reset();
    wrap_en = 1'b0;
    run_b2b("wall_approach", 15, 16, 12, 1, 0, 2'b00, -1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 0, 0, 2'b00);
      n_cmp++;
      if (got !== mk(1'b0, 31, 12, 2'b00) || wall_hit !== 1'b1) begin
        n_err++;
        $display("FAIL wall_tick%0d: got v=%b x=%0d y=%0d dir=%0d wall=%b, required v=0 x=31 y=12 dir=0 wall=1",
                 i, got.valid, got.x, got.y, got.d, wall_hit);
      end
    end
    do_reset();
    n_cmp++;
    if (got !== mk(1'b0, 16, 12, 2'b00) || wall_hit !== 1'b0) begin
      n_err++;
      $display("FAIL wall_reset: got v=%b x=%0d y=%0d dir=%0d wall=%b, required v=0 x=16 y=12 dir=0 wall=0",
               got.valid, got.x, got.y, got.d, wall_hit);
    end
    wrap_en = 1'b1;
  endtask

  task automatic test_pause();
    pause = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, 0, 2'b00);
      n_cmp++;
      if (got !== mk(1'b0, 16, 12, 2'b00)) begin
        n_err++;
        $display("FAIL paused_tick%0d: got v=%b x=%0d y=%0d, required v=0 x=16 y=12",
                 i, got.valid, got.x, got.y);
      end
    end
    pause = 1'b0;
    cycle();
    pause = 1'b1;
    tick(1'b0, 0, 0, 2'b00);
    pause = 1'b0;
    n_cmp++;
    if (got !== mk(1'b0, 16, 12, 2'b00)) begin
      n_err++;
      $display("FAIL tick_with_pause: got v=%b x=%0d y=%0d, required v=0 x=16 y=12",
               got.valid, got.x, got.y);
    end
    cycle();
    tick(1'b1, 17, 12, 2'b00);
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL unpause_step: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
               got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
    end
  endtask

  task automatic test_rst_tick();
    press(4'b0100);
    tick(1'b1, 17, 13, 2'b01);
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL turn_down: got v=%b x=%0d y=%0d dir=%0d, required v=1 x=%0d y=%0d dir=%0d",
               got.valid, got.x, got.y, got.d, e.x, e.y, e.d);
    end
    rst = 1'b1;
    tick(1'b0, 0, 0, 2'b00);
    rst = 1'b0;
    n_cmp++;
    if (got !== mk(1'b0, 16, 12, 2'b00)) begin
      n_err++;
      $display("FAIL rst_with_tick: got v=%b x=%0d y=%0d dir=%0d, required v=0 x=16 y=12 dir=0",
               got.valid, got.x, got.y, got.d);
    end
  endtask

  initial begin
    rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    step_tick = 1'b0;
    pause     = 1'b0;
    wrap_en   = 1'b1;
    test_reset();
    test_straight();
    test_reversal();
    test_wrap();
    test_wall();
    test_pause();
    test_rst_tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
